// File: rtl/coherent_qpsk_receiver_pkg.sv
// Shared types and defaults for the coherent QPSK receive path.
// The Gray mapping helpers convert between quadrant ordinals and line dibits.
package photonic_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HUNT     = 2'd1,
    PREAMBLE = 2'd2,
    TRACK    = 2'd3
  } rx_state_t;

  localparam int DEF_SAMPLE_W         = 12;
  localparam int DEF_PREAMBLE_LEN     = 8;
  localparam logic [15:0] DEF_PREAMBLE = 16'h72D0;
  localparam int DEF_POWER_THRESH     = 256;
  localparam int DEF_ENERGY_RUN       = 4;
  localparam int DEF_ERR_THRESH       = 512;
  localparam int DEF_LOSS_COUNT       = 16;
  localparam int DEF_PREAMBLE_TIMEOUT = 64;
  localparam int DEF_FIFO_DEPTH       = 4;

  function automatic logic [1:0] ord_to_dibit(input logic [1:0] o);
    case (o)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] dibit_to_ord(input logic [1:0] d);
    case (d)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/rx_symbol_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only when a pop
// frees a slot on the same edge.
module rx_symbol_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push, pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign pop     = rd_en && !empty;
  assign push    = wr_en && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/coherent_qpsk_receiver.sv
// QPSK receiver: energy detect, preamble search over 4 phase ambiguities,
// derotation/slicing, lock monitoring and a handshaked symbol FIFO.
module coherent_qpsk_receiver
  import photonic_rx_pkg::*;
#(
  parameter int SAMPLE_W         = DEF_SAMPLE_W,
  parameter int PREAMBLE_LEN     = DEF_PREAMBLE_LEN,
  parameter logic [2*PREAMBLE_LEN-1:0] PREAMBLE = DEF_PREAMBLE,
  parameter int POWER_THRESH     = DEF_POWER_THRESH,
  parameter int ENERGY_RUN       = DEF_ENERGY_RUN,
  parameter int ERR_THRESH       = DEF_ERR_THRESH,
  parameter int LOSS_COUNT       = DEF_LOSS_COUNT,
  parameter int PREAMBLE_TIMEOUT = DEF_PREAMBLE_TIMEOUT,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SAMPLE_W-1:0]           sample_i,
  input  logic [SAMPLE_W-1:0]           sample_q,
  input  logic                          sample_valid,
  output logic [1:0]                    sym_data,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic                          carrier_locked,
  output logic [1:0]                    rot_state,
  output logic [SAMPLE_W+1:0]           phase_err,
  output logic [1:0]                    rx_state,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int EW = $clog2(ENERGY_RUN + 1);
  localparam int CW = $clog2(PREAMBLE_TIMEOUT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int SRW = 2 * PREAMBLE_LEN;
  localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W:0]   PWR_T = (SAMPLE_W+1)'(POWER_THRESH);
  localparam logic [SAMPLE_W+1:0] ERR_T = (SAMPLE_W+2)'(ERR_THRESH);

  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    if (!x[SAMPLE_W-1]) return x;
    if (x == S_MIN)     return S_MAX;
    return -x;
  endfunction

  function automatic logic match_k(input logic [SRW-1:0] sr, input logic [1:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < PREAMBLE_LEN; i++)
      if (2'(sr[2*i +: 2] + k) != PREAMBLE[2*i +: 2]) ok = 1'b0;
    return ok;
  endfunction

  // stage 1 registers
  logic                  vld_pipe_q, vld_pipe_d;
  logic                  present_q, present_d;
  logic [1:0]            r_q, r_d;
  logic [SAMPLE_W+1:0]   err_q, err_d;
  logic [SAMPLE_W-1:0]   abs_i, abs_q;
  logic [SAMPLE_W:0]     mag;
  logic [SAMPLE_W+1:0]   si_x, sq_x;

  // stage 2 state
  rx_state_t             state_q, state_d;
  logic [EW-1:0]         energy_q, energy_d;
  logic [SRW-1:0]        sr_q, sr_d, sr_shift;
  logic [CW-1:0]         symcnt_q, symcnt_d;
  logic [LW-1:0]         loss_q, loss_d;
  logic [1:0]            rot_q, rot_d, k_sel;
  logic                  overflow_q, overflow_d;
  logic                  match_any, bad, wr_en, fifo_full, fifo_empty, pop;
  logic [SAMPLE_W+1:0]   err_abs;
  logic [1:0]            wr_data;

  always_comb begin
    abs_i      = sat_abs(sample_i);
    abs_q      = sat_abs(sample_q);
    mag        = {1'b0, abs_i} + {1'b0, abs_q};
    si_x       = {{2{sample_i[SAMPLE_W-1]}}, sample_i};
    sq_x       = {{2{sample_q[SAMPLE_W-1]}}, sample_q};
    vld_pipe_d = sample_valid;
    present_d  = present_q;
    r_d        = r_q;
    err_d      = err_q;
    if (sample_valid) begin
      present_d = (mag >= PWR_T);
      // quadrant ordinal: Q sign is the MSB, I xor Q sign the LSB
      r_d       = {sample_q[SAMPLE_W-1], sample_i[SAMPLE_W-1] ^ sample_q[SAMPLE_W-1]};
      err_d     = (sample_i[SAMPLE_W-1] ? -sq_x : sq_x) - (sample_q[SAMPLE_W-1] ? -si_x : si_x);
    end
  end

  assign sr_shift = {r_q, sr_q[SRW-1:2]};
  assign err_abs  = err_q[SAMPLE_W+1] ? -err_q : err_q;
  assign bad      = !present_q || (err_abs > ERR_T);

  // descending scan so the lowest matching rotation is the one kept
  always_comb begin
    match_any = 1'b0;
    k_sel     = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (match_k(sr_shift, 2'(k))) begin
        match_any = 1'b1;
        k_sel     = 2'(k);
      end
  end

  always_comb begin
    state_d  = state_q;
    energy_d = energy_q;
    sr_d     = sr_q;
    symcnt_d = symcnt_q;
    loss_d   = loss_q;
    rot_d    = rot_q;
    wr_en    = 1'b0;
    wr_data  = ord_to_dibit(2'(r_q + rot_q));
    unique case (state_q)
      IDLE: state_d = HUNT;
      HUNT: if (vld_pipe_q) begin
        if (present_q) begin
          energy_d = energy_q + 1'b1;
          if (energy_d == EW'(ENERGY_RUN)) begin
            state_d  = photonic_rx_pkg::PREAMBLE;
            energy_d = '0;
            sr_d     = '0;
            symcnt_d = '0;
          end
        end else energy_d = '0;
      end
      photonic_rx_pkg::PREAMBLE: if (vld_pipe_q) begin
        if (!present_q) begin
          state_d  = HUNT;
          energy_d = '0;
        end else begin
          sr_d     = sr_shift;
          symcnt_d = symcnt_q + 1'b1;
          if (symcnt_d >= CW'(PREAMBLE_LEN) && match_any) begin
            state_d = TRACK;
            rot_d   = k_sel;
            loss_d  = '0;
          end else if (symcnt_d >= CW'(PREAMBLE_TIMEOUT)) begin
            state_d  = HUNT;
            energy_d = '0;
          end
        end
      end
      TRACK: if (vld_pipe_q) begin
        wr_en = 1'b1;
        if (bad) begin
          loss_d = loss_q + 1'b1;
          if (loss_d == LW'(LOSS_COUNT)) begin
            state_d  = HUNT;
            energy_d = '0;
            loss_d   = '0;
          end
        end else loss_d = '0;
      end
    endcase
  end

  assign pop = sym_valid && sym_ready;

  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (wr_en && fifo_full && !pop) overflow_d = 1'b1;
  end

  rx_symbol_fifo #(.WIDTH(2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (sym_ready),
    .rd_data (sym_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= 1'b0;
      present_q  <= 1'b0;
      r_q        <= '0;
      err_q      <= '0;
      state_q    <= IDLE;
      energy_q   <= '0;
      sr_q       <= '0;
      symcnt_q   <= '0;
      loss_q     <= '0;
      rot_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      present_q  <= present_d;
      r_q        <= r_d;
      err_q      <= err_d;
      state_q    <= state_d;
      energy_q   <= energy_d;
      sr_q       <= sr_d;
      symcnt_q   <= symcnt_d;
      loss_q     <= loss_d;
      rot_q      <= rot_d;
      overflow_q <= overflow_d;
    end
  end

  assign sym_valid      = !fifo_empty;
  assign carrier_locked = (state_q == TRACK);
  assign rot_state      = rot_q;
  assign phase_err      = err_q;
  assign rx_state       = state_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/coherent_qpsk_receiver.md
Name: coherent_qpsk_receiver

Overview:
- Receive-side counterpart of the coherent I/Q modulator on the integrated photonic chip; consumes digitised I/Q photodetector samples, one sample per symbol.
- Functions: detects signal energy, finds a known QPSK preamble under any of the 4 quadrant phase ambiguities, then slices and derotates payload symbols.
- Monitors decision-directed phase error to declare and drop carrier lock.
- Delivers symbols through a small FIFO with a valid/ready handshake to the link layer.

Parameters:
- SAMPLE_W, 12: signed I/Q sample width.
- PREAMBLE_LEN, 8: preamble length in symbols.
- PREAMBLE, 16'h72D0: preamble ordinals; bits [2i+1:2i] hold symbol i, i=0 received first.
- POWER_THRESH, 256: minimum |I|+|Q| for a sample to count as present.
- ENERGY_RUN, 4: consecutive present samples needed to leave HUNT.
- ERR_THRESH, 512: maximum |phase error| for a good symbol.
- LOSS_COUNT, 16: consecutive bad symbols that drop lock.
- PREAMBLE_TIMEOUT, 64: symbols allowed in PREAMBLE before returning to HUNT.
- FIFO_DEPTH, 4: output FIFO entries, power of two.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset.
- sample_i  in  SAMPLE_W  signed in-phase sample.
- sample_q  in  SAMPLE_W  signed quadrature sample.
- sample_valid  in  1  sample strobe; no backpressure.
- sym_data  out  2  Gray dibit, FIFO head.
- sym_valid  out  1  FIFO non-empty.
- sym_ready  in  1  consumer accepts head.
- carrier_locked  out  1  high in TRACK.
- rot_state  out  2  detected correction k.
- phase_err  out  SAMPLE_W+2  signed error of last sample.
- rx_state  out  2  IDLE/HUNT/PREAMBLE/TRACK encoding.
- overflow  out  1  sticky drop flag.
- clear_overflow  in  1  synchronous clear of overflow.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.

Interface rule: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: every output 0, FSM in IDLE, all counters and the shift register cleared. Asserting reset mid-operation clears FIFO contents and all state immediately.
- Stage 1 (edge after sample_valid):
  - Register signs and abs values; abs of the most negative value saturates to 2^(SAMPLE_W-1)-1.
  - present = (|I|+|Q| >= POWER_THRESH), computed at SAMPLE_W+1 bits.
  - e = sgn(I)*Q - sgn(Q)*I, with sgn = +1 for >=0, else -1; phase_err updates here.
  - Ordinal r: (I>=0,Q>=0)=0, (I<0,Q>=0)=1, (I<0,Q<0)=2, (I>=0,Q<0)=3.
- Stage 2 (next edge): FSM update and FIFO write. Latency from sample accept edge to sym_valid is 2 edges when the FIFO was empty.
- Cycles without sample_valid: pipeline and FSM hold.
- IDLE: enter HUNT on the first clock after reset.
- HUNT:
  - Count consecutive present samples; a non-present sample zeroes the count.
  - When the count reaches ENERGY_RUN, go to PREAMBLE and clear the shift register and symbol count.
- PREAMBLE:
  - Shift r into a PREAMBLE_LEN-deep ordinal register.
  - Once PREAMBLE_LEN symbols are collected, test k=0..3 in order: match when (r_i + k) mod 4 == PREAMBLE_i for all i. The lowest matching k wins.
  - On match: latch rot_state=k, go to TRACK, clear the loss counter.
  - A non-present sample, or PREAMBLE_TIMEOUT symbols without a match, returns to HUNT.
  - Preamble symbols are never written to the FIFO.
- TRACK:
  - Corrected ordinal c = (r + rot_state) mod 4, mapped back to a dibit: 0->00, 1->10, 2->11, 3->01. Write c to the FIFO.
  - Bad symbol = !present or |e| > ERR_THRESH. A bad symbol increments the loss counter (bad symbols are still written); a good symbol zeroes it.
  - When the counter reaches LOSS_COUNT, go to HUNT. carrier_locked deasserts on that same edge; rot_state holds.
- FIFO:
  - Show-ahead; a pop occurs on sym_valid && sym_ready.
  - Write when full with no simultaneous pop: drop the new symbol and set overflow. Full with a simultaneous pop: the write is accepted.
  - clear_overflow clears overflow; a simultaneous new overflow wins.
  - Pointers wrap modulo FIFO_DEPTH.
  - Leaving TRACK does not flush the FIFO.

Decomposition:
- Package photonic_rx_pkg holds:
  - rx_state_t enum: IDLE=0, HUNT=1, PREAMBLE=2, TRACK=3;
  - dibit_to_ord and ord_to_dibit functions;
  - default threshold constants.
- Sub-module rx_symbol_fifo: synchronous, parameterised width and depth, with level and full/empty outputs.

Test Plan:
- Reset, then 4 samples (+600,+600) followed by preamble ordinals 0,0,1,3,2,0,3,1 at magnitude 600 and payload ordinal 2 -> rx_state 1->2->3; rot_state=0; carrier_locked high; first sym_data=11, two edges after its sample.
- Same preamble with every ordinal +1 (channel rotated +90°) -> rot_state=3; payload sample (I<0,Q<0) emitted as dibit 10.
- In TRACK, 16 consecutive samples (+600,+0), giving |e|=600>512 -> carrier_locked falls on the 16th stage-2 edge and rx_state=HUNT. Inject 15 bad then 1 good -> lock retained.
- sym_ready low with 6 payload symbols -> fifo_level=4, overflow=1, first 4 symbols preserved. With full FIFO, pop and write in the same cycle -> level stays 4, overflow unchanged.
- PREAMBLE entered but 64 random non-matching symbols -> return to HUNT, no FIFO writes. A sample (-2048,-2048) -> abs saturates, present=1.
- rst_n pulsed low mid-TRACK with FIFO at 3 -> all outputs 0 asynchronously, fifo_level=0, rx_state IDLE then HUNT.
